nlc_adc_int2fp_frontend: RTL and testbench

Upstream feeder for the NLC wrapper. Accepts raw signed ADC samples for the 16 time-interleaved channels, tags each sample with its channel index, and converts it exactly to IEEE-754 single precision. The result feeds the NLC floating-point datapath: mean shift, stdev scaling and 6th-order polynomial. The block is a 3-stage pipeline with a srdyi/srdyo valid-only handshake, which matches the rest of the NLC datapath.

---
 rtl/nlc_adc_int2fp_frontend.sv | 114 +++++++++++
 tb/tb_nlc_adc_int2fp_frontend.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nlc_adc_int2fp_frontend.sv
// Signed ADC sample to IEEE-754 float32 converter with per-channel tagging.
// Input capture, abs/sign, leading-one detect, then pack into the output registers.
module nlc_adc_int2fp_frontend #(
    parameter int ADC_W = 21,
    parameter int N_CH  = 16
) (
    input  logic                      clk_port,
    input  logic                      reset_port,
    input  logic signed [ADC_W-1:0]   ch_x_adc_port,
    input  logic                      srdyi_port,
    input  logic                      frame_start_port,
    output logic [31:0]               ch_x_fp_port,
    output logic [$clog2(N_CH)-1:0]   ch_idx_port,
    output logic                      srdyo_port,
    output logic                      frame_end_port
);

    localparam int CW = $clog2(N_CH);
    localparam int PW = $clog2(ADC_W);
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    function automatic logic [ADC_W-1:0] abs_mag(input logic signed [ADC_W-1:0] x);
        abs_mag = x[ADC_W-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [PW-1:0] lead_one(input logic [ADC_W-1:0] m);
        lead_one = '0;
        for (int i = 0; i < ADC_W; i++) begin
            if (m[i]) lead_one = PW'(i);
        end
    endfunction

    // The magnitude never exceeds 24 significant bits, so the pack is exact.
    function automatic logic [31:0] pack_fp(input logic sign, input logic [ADC_W-1:0] m,
                                            input logic [PW-1:0] p, input logic zero);
        logic [23:0] m24;
        logic [4:0]  sh;
        logic [7:0]  e;
        m24        = 24'(m);
        m24[5'(p)] = 1'b0;
        sh         = 5'd23 - 5'(p);
        e          = 8'd127 + 8'(p);
        m24        = m24 << sh;
        pack_fp    = zero ? 32'h0000_0000 : {sign, e, m24[22:0]};
    endfunction

    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            w_tag;
    logic                     r_vld_p0;
    logic                     r_vld_p1;
    logic                     r_vld_p2;
    logic signed [ADC_W-1:0]  r_x_p0;
    logic [CW-1:0]            r_tag_p0;
    logic                     r_sign_p1;
    logic [ADC_W-1:0]         r_mag_p1;
    logic [CW-1:0]            r_tag_p1;
    logic                     r_sign_p2;
    logic [ADC_W-1:0]         r_mag_p2;
    logic [PW-1:0]            r_pos_p2;
    logic                     r_zero_p2;
    logic [CW-1:0]            r_tag_p2;
    logic [31:0]              w_fp_p2;

    assign w_tag   = frame_start_port ? '0 : r_cnt;
    assign w_fp_p2 = pack_fp(r_sign_p2, r_mag_p2, r_pos_p2, r_zero_p2);

    always_ff @(posedge clk_port or negedge reset_port) begin
        if (!reset_port) begin
            r_cnt          <= '0;
            r_vld_p0       <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_vld_p2       <= 1'b0;
            srdyo_port     <= 1'b0;
            frame_end_port <= 1'b0;
            ch_x_fp_port   <= 32'h0000_0000;
            ch_idx_port    <= '0;
        end else begin
            r_vld_p0 <= srdyi_port;
            if (srdyi_port) r_cnt <= w_tag + CW'(1);
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            // output stage: data holds between valid samples, strobes are one-cycle
            srdyo_port     <= r_vld_p2;
            frame_end_port <= r_vld_p2 && (r_tag_p2 == LAST_CH);
            if (r_vld_p2) begin
                ch_x_fp_port <= w_fp_p2;
                ch_idx_port  <= r_tag_p2;
            end
        end
    end

    always_ff @(posedge clk_port) begin
        // p0: accepted sample and its channel tag
        if (srdyi_port) begin
            r_x_p0   <= ch_x_adc_port;
            r_tag_p0 <= w_tag;
        end
        // p1: sign and magnitude
        if (r_vld_p0) begin
            r_sign_p1 <= r_x_p0[ADC_W-1];
            r_mag_p1  <= abs_mag(r_x_p0);
            r_tag_p1  <= r_tag_p0;
        end
        // p2: leading-one position and zero flag
        if (r_vld_p1) begin
            r_sign_p2 <= r_sign_p1;
            r_mag_p2  <= r_mag_p1;
            r_pos_p2  <= lead_one(r_mag_p1);
            r_zero_p2 <= (r_mag_p1 == '0);
            r_tag_p2  <= r_tag_p1;
        end
    end

endmodule

// File: tb/tb_nlc_adc_int2fp_frontend.sv
// Scoreboard bench for nlc_adc_int2fp_frontend: directed corners plus a random sweep.
module tb_nlc_adc_int2fp_frontend;

    localparam int ADC_W = 21;
    localparam int N_CH  = 16;

    logic                    clk_port;
    logic                    reset_port;
    logic signed [ADC_W-1:0] ch_x_adc_port;
    logic                    srdyi_port;
    logic                    frame_start_port;
    logic [31:0]             ch_x_fp_port;
    logic [3:0]              ch_idx_port;
    logic                    srdyo_port;
    logic                    frame_end_port;

    nlc_adc_int2fp_frontend #(.ADC_W(ADC_W), .N_CH(N_CH)) dut (
        .clk_port         (clk_port),
        .reset_port       (reset_port),
        .ch_x_adc_port    (ch_x_adc_port),
        .srdyi_port       (srdyi_port),
        .frame_start_port (frame_start_port),
        .ch_x_fp_port     (ch_x_fp_port),
        .ch_idx_port      (ch_idx_port),
        .srdyo_port       (srdyo_port),
        .frame_end_port   (frame_end_port)
    );

    typedef struct {
        logic [31:0] fp;
        logic [3:0]  idx;
        logic        fe;
        int          edg;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_out = 0;
    int          n_fe  = 0;
    int          cyc   = 0;
    int          m_cnt = 0;
    logic [31:0] hold_fp  = '0;
    logic [3:0]  hold_idx = '0;

    initial clk_port = 1'b0;
    always #5 clk_port = ~clk_port;
    always @(posedge clk_port) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    // Float32 reference derived from the double-precision encoding of the integer.
    function automatic logic [31:0] ref_fp(input int x);
        logic signed [ADC_W-1:0] xs;
        int                      xi;
        real                     r;
        logic [63:0]             d;
        logic [10:0]             ed;
        xs = x[ADC_W-1:0];
        xi = xs;
        if (xi == 0) return 32'h0;
        r  = xi;
        d  = $realtobits(r);
        ed = d[62:52] - 11'd1023 + 11'd127;
        return {d[63], ed[7:0], d[51:29]};
    endfunction

    task automatic send(input int x, input bit fs, input bit use_k, input logic [31:0] k);
        exp_t e;
        int   tag;
        @(posedge clk_port); #1;
        ch_x_adc_port    = x[ADC_W-1:0];
        srdyi_port       = 1'b1;
        frame_start_port = fs;
        tag   = fs ? 0 : m_cnt;
        m_cnt = (tag + 1) % N_CH;
        e.fp  = use_k ? k : ref_fp(x);
        e.idx = 4'(tag);
        e.fe  = (tag == N_CH - 1);
        e.edg = cyc + 1;
        q.push_back(e);
        n_acc++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_port); #1;
            srdyi_port       = 1'b0;
            frame_start_port = $urandom_range(0, 1) == 1;
            ch_x_adc_port    = ADC_W'($urandom);
        end
    endtask

    task automatic rst_assert();
        reset_port       = 1'b0;
        srdyi_port       = 1'b0;
        frame_start_port = 1'b0;
        n_acc   -= q.size();
        q.delete();
        m_cnt    = 0;
        hold_fp  = '0;
        hold_idx = '0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_fp"},    ch_x_fp_port, 32'h0);
        chk({tag, "_idx"},   32'(ch_idx_port), 32'h0);
        chk({tag, "_srdyo"}, 32'(srdyo_port), 32'h0);
        chk({tag, "_fe"},    32'(frame_end_port), 32'h0);
    endtask

    always @(negedge clk_port) begin
        exp_t e;
        if (srdyo_port) begin
            n_out++;
            if (frame_end_port) n_fe++;
            if (q.size() == 0) begin
                chk("spurious_srdyo", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("fp",  ch_x_fp_port, e.fp);
                chk("idx", 32'(ch_idx_port), 32'(e.idx));
                chk("fe",  32'(frame_end_port), 32'(e.fe));
                chk("lat", cyc, e.edg + 3);
                hold_fp  = e.fp;
                hold_idx = e.idx;
            end
        end else begin
            chk("hold_fp",  ch_x_fp_port, hold_fp);
            chk("hold_idx", 32'(ch_idx_port), 32'(hold_idx));
            chk("fe_idle",  32'(frame_end_port), 32'h0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int f0;
        int w;
        ch_x_adc_port    = '0;
        srdyi_port       = 1'b0;
        frame_start_port = 1'b0;
        reset_port       = 1'b0;
        repeat (3) @(negedge clk_port);
        chk_zero_outputs("reset");
        @(posedge clk_port); #1;
        reset_port = 1'b1;

        o0 = n_out;
        send(23333, 1'b0, 1'b1, 32'h46B64A00);
        idle(6);
        chk("single_cnt", n_out - o0, 1);

        send(0,        1'b0, 1'b1, 32'h00000000);
        send(1,        1'b0, 1'b1, 32'h3F800000);
        send(-1,       1'b0, 1'b1, 32'hBF800000);
        send(1048575,  1'b0, 1'b1, 32'h497FFFF0);
        send(-1048576, 1'b0, 1'b1, 32'hC9800000);
        idle(6);

        f0 = n_fe;
        for (int i = 0; i < 34; i++) send(i * 37 - 500, i == 0, 1'b0, 32'h0);
        idle(6);
        chk("wrap_fe_cnt", n_fe - f0, 2);
        chk("wrap_last_idx", 32'(ch_idx_port), 32'd1);

        send(100, 1'b0, 1'b0, 32'h0);
        idle(1);
        send(-200, 1'b0, 1'b0, 32'h0);
        idle(2);
        send(300, 1'b1, 1'b0, 32'h0);
        idle(6);
        chk("resync_idx", 32'(ch_idx_port), 32'd0);

        o0 = n_out;
        send(5, 1'b0, 1'b0, 32'h0);
        send(6, 1'b0, 1'b0, 32'h0);
        send(7, 1'b0, 1'b0, 32'h0);
        @(posedge clk_port); #1;
        rst_assert();
        repeat (3) begin
            @(negedge clk_port);
            chk_zero_outputs("midrst");
        end
        @(posedge clk_port); #1;
        reset_port = 1'b1;
        idle(5);
        chk("midrst_drop", n_out - o0, 0);
        send(-1, 1'b0, 1'b1, 32'hBF800000);
        idle(6);
        chk("midrst_idx", 32'(ch_idx_port), 32'd0);

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send(int'($urandom), $urandom_range(0, 31) == 0, 1'b0, 32'h0);
        end
        idle(1);

        w = 0;
        while (q.size() != 0 && w < 20) begin
            @(negedge clk_port);
            w++;
        end
        idle(2);
        chk("drain", q.size(), 0);
        chk("acc_vs_out", n_out, n_acc);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
